// File: rtl/key_debounce.sv
// Key synchroniser and debouncer: per-key clean level plus 1-clk press/release pulses.
// Optional auto-repeat of key_press while held is enabled by defining AUTOREPEAT_EN.
module key_debounce #(
    parameter int N_KEYS     = 3,
    parameter int DIV        = 50000,
    parameter int DEB_TICKS  = 20,
    parameter int ACTIVE_LOW = 0,
    parameter int REP_DELAY  = 500,
    parameter int REP_PERIOD = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release
);

    localparam int DIV_W = $clog2(DIV);
    localparam int DEB_W = $clog2(DEB_TICKS);
    localparam logic [N_KEYS-1:0] IDLE_PIN = (ACTIVE_LOW != 0) ? {N_KEYS{1'b1}} : {N_KEYS{1'b0}};
`ifdef AUTOREPEAT_EN
    // Repeat counter runs 0..REP_DELAY+REP_PERIOD-1, folding back to REP_DELAY on each repeat.
    localparam int REP_MAX = REP_DELAY + REP_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX);
`endif

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic [DIV_W-1:0]  div_reg;
    logic              tick;
    logic [N_KEYS-1:0] sync1_reg;
    logic [N_KEYS-1:0] sync2_reg;
    logic [N_KEYS-1:0] s;

    assign tick = (div_reg == DIV_W'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_reg <= '0;
        end else if (tick) begin
            div_reg <= '0;
        end else begin
            div_reg <= div_reg + DIV_W'(1);
        end
    end

    // Synchroniser idles at the released pin level so reset never looks like a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= IDLE_PIN;
            sync2_reg <= IDLE_PIN;
        end else begin
            sync1_reg <= key_in;
            sync2_reg <= sync1_reg;
        end
    end

    assign s = sync2_reg ^ IDLE_PIN;

    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
        state_t           state_reg, state_next;
        logic [DEB_W-1:0] cnt_reg, cnt_next;
        logic             level_reg, level_next;
        logic             press_reg, press_next;
        logic             release_reg, release_next;
        logic             deb_done;
`ifdef AUTOREPEAT_EN
        logic [REP_W-1:0] rep_reg, rep_next;
        logic             rep_hit;

        assign rep_hit = (32'(rep_reg) + 32'd1 == 32'(REP_DELAY)) ||
                         (32'(rep_reg) + 32'd1 == 32'(REP_MAX));
`endif

        assign deb_done = (32'(cnt_reg) + 32'd1 == 32'(DEB_TICKS));

        always_comb begin
            state_next   = state_reg;
            cnt_next     = cnt_reg;
            level_next   = level_reg;
            press_next   = 1'b0;
            release_next = 1'b0;
`ifdef AUTOREPEAT_EN
            rep_next     = rep_reg;
`endif
            if (tick) begin
                unique case (state_reg)
                    IDLE: begin
                        if (s[gi]) begin
                            state_next = PRESS_WAIT;
                            cnt_next   = DEB_W'(1);
                        end
                    end
                    PRESS_WAIT: begin
                        if (!s[gi]) begin
                            state_next = IDLE;
                            cnt_next   = '0;
                        end else if (deb_done) begin
                            state_next = HELD;
                            cnt_next   = '0;
                            level_next = 1'b1;
                            press_next = 1'b1;
`ifdef AUTOREPEAT_EN
                            rep_next   = '0;
`endif
                        end else begin
                            cnt_next = cnt_reg + DEB_W'(1);
                        end
                    end
                    HELD: begin
                        if (!s[gi]) begin
                            state_next = RELEASE_WAIT;
                            cnt_next   = DEB_W'(1);
                        end else begin
`ifdef AUTOREPEAT_EN
                            if (rep_hit) begin
                                press_next = 1'b1;
                                rep_next   = REP_W'(REP_DELAY);
                            end else begin
                                rep_next = rep_reg + REP_W'(1);
                            end
`endif
                        end
                    end
                    RELEASE_WAIT: begin
                        if (s[gi]) begin
                            state_next = HELD;
                            cnt_next   = '0;
                        end else if (deb_done) begin
                            state_next   = IDLE;
                            cnt_next     = '0;
                            level_next   = 1'b0;
                            release_next = 1'b1;
`ifdef AUTOREPEAT_EN
                            rep_next     = '0;
`endif
                        end else begin
                            cnt_next = cnt_reg + DEB_W'(1);
                        end
                    end
                    default: begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_reg   <= IDLE;
                cnt_reg     <= '0;
                level_reg   <= 1'b0;
                press_reg   <= 1'b0;
                release_reg <= 1'b0;
`ifdef AUTOREPEAT_EN
                rep_reg     <= '0;
`endif
            end else begin
                state_reg   <= state_next;
                cnt_reg     <= cnt_next;
                level_reg   <= level_next;
                press_reg   <= press_next;
                release_reg <= release_next;
`ifdef AUTOREPEAT_EN
                rep_reg     <= rep_next;
`endif
            end
        end

        assign key_level[gi]   = level_reg;
        assign key_press[gi]   = press_reg;
        assign key_release[gi] = release_reg;
    end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: table-driven segments, hand sequences and random stimulus,
// all compared every cycle against a run-length reference model (both pin polarities).
module tb_key_debounce;

    localparam int NK   = 3;
    localparam int DIV  = 4;
    localparam int DEB  = 3;
    localparam int RDLY = 5;
    localparam int RPER = 2;
`ifdef AUTOREPEAT_EN
    localparam int AR = 1;
`else
    localparam int AR = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [NK-1:0] key_in;
    logic [NK-1:0] key_in_low;
    logic [NK-1:0] lvl_h, prs_h, rel_h;
    logic [NK-1:0] lvl_l, prs_l, rel_l;

    always #5 clk = ~clk;
    assign key_in_low = ~key_in;

    key_debounce #(.N_KEYS(NK), .DIV(DIV), .DEB_TICKS(DEB), .ACTIVE_LOW(0),
                   .REP_DELAY(RDLY), .REP_PERIOD(RPER)) u_dut (
        .clk(clk), .rst(rst), .key_in(key_in),
        .key_level(lvl_h), .key_press(prs_h), .key_release(rel_h)
    );

    key_debounce #(.N_KEYS(NK), .DIV(DIV), .DEB_TICKS(DEB), .ACTIVE_LOW(1),
                   .REP_DELAY(RDLY), .REP_PERIOD(RPER)) u_low (
        .clk(clk), .rst(rst), .key_in(key_in_low),
        .key_level(lvl_l), .key_press(prs_l), .key_release(rel_l)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: pin delay line, tick phase, and per key the run length of samples
    // disagreeing with the accepted level plus the count of steady held ticks.
    logic [NK-1:0] m_sync1, m_sync2;
    int            m_phase;
    int            m_run  [NK];
    int            m_held [NK];
    logic [NK-1:0] m_level, m_press, m_release;
    int            seen_press   [NK];
    int            seen_release [NK];

    typedef struct packed {
        logic [2:0]      keys;
        logic [7:0]      ticks;
        logic [2:0][3:0] press;
        logic [2:0][3:0] rel;
        logic [2:0]      level;
    } seg_t;

    seg_t tbl [11];

    function automatic seg_t mk(logic [2:0] keys, int ticks, int p2, int p1, int p0,
                                int r2, int r1, int r0, logic [2:0] level);
        seg_t r;
        r.keys     = keys;
        r.ticks    = 8'(ticks);
        r.press[2] = 4'(p2);
        r.press[1] = 4'(p1);
        r.press[0] = 4'(p0);
        r.rel[2]   = 4'(r2);
        r.rel[1]   = 4'(r1);
        r.rel[0]   = 4'(r0);
        r.level    = level;
        return r;
    endfunction

    task automatic model_reset();
        m_sync1   = '0;
        m_sync2   = '0;
        m_phase   = 0;
        m_level   = '0;
        m_press   = '0;
        m_release = '0;
        for (int i = 0; i < NK; i++) begin
            m_run[i]  = 0;
            m_held[i] = 0;
        end
    endtask

    task automatic model_step(input logic [NK-1:0] k);
        logic          tk;
        logic [NK-1:0] smp;
        tk        = (m_phase == DIV - 1);
        smp       = m_sync2;
        m_sync2   = m_sync1;
        m_sync1   = k;
        m_phase   = tk ? 0 : m_phase + 1;
        m_press   = '0;
        m_release = '0;
        if (tk) begin
            for (int i = 0; i < NK; i++) begin
                if (smp[i] != m_level[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_level[i] = smp[i];
                        m_run[i]   = 0;
                        if (smp[i]) begin
                            m_press[i] = 1'b1;
                            m_held[i]  = 0;
                        end else begin
                            m_release[i] = 1'b1;
                        end
                    end
                end else begin
                    if (AR == 1 && m_level[i] && m_run[i] == 0) begin
                        m_held[i]++;
                        if (m_held[i] == RDLY ||
                            (m_held[i] > RDLY && (m_held[i] - RDLY) % RPER == 0))
                            m_press[i] = 1'b1;
                    end
                    m_run[i] = 0;
                end
            end
        end
    endtask

    task automatic check_vec(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        check_vec("level_hi",   lvl_h, m_level);
        check_vec("press_hi",   prs_h, m_press);
        check_vec("release_hi", rel_h, m_release);
        check_vec("level_lo",   lvl_l, m_level);
        check_vec("press_lo",   prs_l, m_press);
        check_vec("release_lo", rel_l, m_release);
    endtask

    task automatic clear_seen();
        for (int i = 0; i < NK; i++) begin
            seen_press[i]   = 0;
            seen_release[i] = 0;
        end
    endtask

    // One clock: drive at negedge, advance model at posedge, compare at the next negedge.
    task automatic cycle(input logic [NK-1:0] k);
        key_in = k;
        @(posedge clk);
        if (rst) model_reset();
        else model_step(k);
        @(negedge clk);
        compare_all();
        for (int i = 0; i < NK; i++) begin
            seen_press[i]   += int'(prs_h[i]);
            seen_release[i] += int'(rel_h[i]);
        end
    endtask

    task automatic ticks_of(input logic [NK-1:0] k, input int n);
        repeat (n * DIV) cycle(k);
    endtask

    initial begin
        tbl[0]  = mk(3'b000,  4, 0, 0, 0,          0, 0, 0, 3'b000);
        tbl[1]  = mk(3'b001, 20, 0, 0, 1 + 7 * AR, 0, 0, 0, 3'b001);
        tbl[2]  = mk(3'b000,  6, 0, 0, 0,          0, 0, 1, 3'b000);
        tbl[3]  = mk(3'b001,  6, 0, 0, 1,          0, 0, 0, 3'b001);
        tbl[4]  = mk(3'b000,  2, 0, 0, 0,          0, 0, 0, 3'b001);
        tbl[5]  = mk(3'b001,  4, 0, 0, AR,         0, 0, 0, 3'b001);
        tbl[6]  = mk(3'b000,  4, 0, 0, 0,          0, 0, 1, 3'b000);
        tbl[7]  = mk(3'b100, 18, 1 + 6 * AR, 0, 0, 0, 0, 0, 3'b100);
        tbl[8]  = mk(3'b000,  4, 0, 0, 0,          1, 0, 0, 3'b000);
        tbl[9]  = mk(3'b111,  4, 1, 1, 1,          0, 0, 0, 3'b111);
        tbl[10] = mk(3'b000,  4, 0, 0, 0,          1, 1, 1, 3'b000);

        rst    = 1'b1;
        key_in = '0;
        model_reset();
        repeat (3) @(negedge clk);
        compare_all();
        $display("reset: level=%b press=%b release=%b", lvl_h, prs_h, rel_h);
        rst = 1'b0;

        // Tick-aligned segments: every tick of a segment samples that segment's pattern.
        for (int n = 0; n < 11; n++) begin
            clear_seen();
            ticks_of(tbl[n].keys, int'(tbl[n].ticks));
            check_vec($sformatf("seg%0d_level", n), lvl_h, tbl[n].level);
            for (int i = 0; i < NK; i++) begin
                check_int($sformatf("seg%0d_press%0d", n, i), seen_press[i], int'(tbl[n].press[i]));
                check_int($sformatf("seg%0d_release%0d", n, i), seen_release[i], int'(tbl[n].rel[i]));
            end
            $display("seg %0d keys=%b ticks=%0d level=%b press=%0d,%0d,%0d release=%0d,%0d,%0d",
                     n, tbl[n].keys, tbl[n].ticks, lvl_h, seen_press[2], seen_press[1],
                     seen_press[0], seen_release[2], seen_release[1], seen_release[0]);
        end

        // Key 1 toggling every tick never sees three equal samples in a row.
        clear_seen();
        for (int t = 0; t < 10; t++) ticks_of((t % 2 == 0) ? 3'b010 : 3'b000, 1);
        ticks_of(3'b000, 4);
        check_int("bounce_press1", seen_press[1], 0);
        check_int("bounce_release1", seen_release[1], 0);
        check_vec("bounce_level", lvl_h, 3'b000);
        $display("bounce: key1 press=%0d release=%0d level=%b", seen_press[1], seen_release[1], lvl_h);

        // Reset while key 0 is held, then release reset with the key still down.
        ticks_of(3'b001, 6);
        check_vec("pre_reset_level", lvl_h, 3'b001);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_vec("async_rst_level_hi", lvl_h, 3'b000);
        check_vec("async_rst_level_lo", lvl_l, 3'b000);
        check_vec("async_rst_press_hi", prs_h, 3'b000);
        check_vec("async_rst_release_hi", rel_h, 3'b000);
        @(negedge clk);
        repeat (3) cycle(3'b001);
        rst = 1'b0;
        clear_seen();
        ticks_of(3'b001, 6);
        check_int("post_reset_press0", seen_press[0], 1);
        check_vec("post_reset_level", lvl_h, 3'b001);
        ticks_of(3'b000, 4);
        check_int("post_reset_release0", seen_release[0], 1);
        $display("reset mid-held: press0=%0d release0=%0d level=%b", seen_press[0], seen_release[0], lvl_h);

        // Random pin activity at two edge rates, unaligned to the tick phase.
        for (int phase = 0; phase < 2; phase++) begin
            int rate;
            rate = (phase == 0) ? 10 : 40;
            clear_seen();
            for (int c = 0; c < 1000; c++) begin
                logic [NK-1:0] k;
                k = key_in;
                for (int i = 0; i < NK; i++)
                    if ($urandom_range(rate - 1, 0) == 0) k[i] = ~k[i];
                cycle(k);
            end
            $display("random rate=1/%0d: press=%0d,%0d,%0d release=%0d,%0d,%0d", rate,
                     seen_press[2], seen_press[1], seen_press[0],
                     seen_release[2], seen_release[1], seen_release[0]);
        end
        ticks_of(3'b000, 6);
        check_vec("final_level", lvl_h, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
